// File: rtl/nios_audio_pio_in_edge.sv
// Avalon-MM input PIO with a synchronizer, a sticky edge-capture register and a maskable level irq.
// Ports: clk, reset_n, address/chipselect/write_n/writedata (slave), in_port (async bus), readdata, irq.
module nios_audio_pio_in_edge #(
    parameter int DATA_WIDTH  = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam logic [2:0] WARM_CLKS = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] data_sync;
    logic [DATA_WIDTH-1:0] d1;
    logic [DATA_WIDTH-1:0] edge_raw;
    logic [DATA_WIDTH-1:0] edge_vec;
    logic [DATA_WIDTH-1:0] edge_capture;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] clr_bits;
    logic [2:0]            warm_cnt;
    logic                  warm_done;
    logic                  wr_en;
    logic [31:0]           rd_word;

    assign data_sync = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == WARM_CLKS);
    assign wr_en     = chipselect & ~write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            d1 <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            d1 <= data_sync;
        end
    end

    // Counts the clocks after reset release until the synchronizer and d1
    // hold real samples; edges seen before then are reset artefacts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            warm_cnt <= '0;
        else if (!warm_done)
            warm_cnt <= warm_cnt + 3'd1;
    end

    always_comb begin
        edge_raw = '0;
        case (EDGE_TYPE)
            0:       edge_raw = data_sync & ~d1;
            1:       edge_raw = ~data_sync & d1;
            default: edge_raw = data_sync ^ d1;
        endcase
    end

    assign edge_vec = warm_done ? edge_raw : '0;
    assign clr_bits = (wr_en && address == 2'd3) ?
                      writedata[DATA_WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            if (wr_en && address == 2'd2)
                irq_mask <= writedata[DATA_WIDTH-1:0];
            // A new edge wins over a same-cycle clear of that bit.
            edge_capture <= (edge_capture & ~clr_bits) | edge_vec;
            irq          <= |(edge_capture & irq_mask);
        end
    end

    always_comb begin
        rd_word = '0;
        case (address)
            2'd0:    rd_word[DATA_WIDTH-1:0] = data_sync;
            2'd2:    rd_word[DATA_WIDTH-1:0] = irq_mask;
            2'd3:    rd_word[DATA_WIDTH-1:0] = edge_capture;
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_word;
    end

endmodule

// File: tb/tb_nios_audio_pio_in_edge.sv
// Scoreboard bench for nios_audio_pio_in_edge: u0 rising-edge, u2 any-edge.
// Ports: shared Avalon bus, per-instance chipselect, in_port, readdata, irq.
module tb_nios_audio_pio_in_edge;

    typedef struct {
        bit          dut;
        bit          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs0, cs2;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in0, in2;
    logic [31:0] rd0, rd2;
    logic        irq0, irq2;

    bit   chk_strobe;
    exp_t sb[$];
    int   checks;
    int   failures;

    always #5 clk = ~clk;

    nios_audio_pio_in_edge #(
        .DATA_WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(cs0), .write_n(write_n), .writedata(writedata),
        .in_port(in0), .readdata(rd0), .irq(irq0)
    );

    nios_audio_pio_in_edge #(
        .DATA_WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) u2 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(cs2), .write_n(write_n), .writedata(writedata),
        .in_port(in2), .readdata(rd2), .irq(irq2)
    );

    // Monitor: a strobed cycle means one expectation is due #1 after this edge.
    initial begin
        bit          s;
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            s = chk_strobe;
            #1;
            if (s) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty: got none required entry");
                end else begin
                    e = sb.pop_front();
                    if (e.kind)
                        act = {31'b0, (e.dut ? irq2 : irq0)};
                    else
                        act = e.dut ? rd2 : rd0;
                    if (act !== e.exp) begin
                        failures++;
                        $display("FAIL %s: got %h required %h",
                                 e.name, act, e.exp);
                    end
                end
            end
        end
    end

    task automatic bus_idle();
        cs0        = 1'b0;
        cs2        = 1'b0;
        write_n    = 1'b1;
        chk_strobe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit d, input logic [1:0] a,
                      input logic [31:0] v);
        @(negedge clk);
        cs0       = (d == 1'b0);
        cs2       = (d == 1'b1);
        write_n   = 1'b0;
        address   = a;
        writedata = v;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic rd(input bit d, input logic [1:0] a,
                      input logic [31:0] v, input string nm);
        exp_t e;
        @(negedge clk);
        address = a;
        e.dut = d; e.kind = 1'b0; e.exp = v; e.name = nm;
        sb.push_back(e);
        chk_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic irq_chk(input bit d, input logic v, input string nm);
        exp_t e;
        @(negedge clk);
        e.dut = d; e.kind = 1'b1; e.exp = {31'b0, v}; e.name = nm;
        sb.push_back(e);
        chk_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic set0(input logic [31:0] v);
        @(negedge clk);
        in0 = v;
    endtask

    task automatic set2(input logic [31:0] v);
        @(negedge clk);
        in2 = v;
    endtask

    task automatic direct(input string nm, input logic [31:0] act,
                          input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, ex);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        address   = 2'd0;
        writedata = '0;
        bus_idle();
        reset_n   = 1'b0;
        in0       = 32'hFFFF_FFFF;
        in2       = 32'h0;
        #12;
        direct("reset_readdata", rd0, 32'h0);
        direct("reset_irq", {31'b0, irq0}, 32'h0);

        // Static high through release must capture nothing.
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++)
            rd(0, 2'd3, 32'h0, "warm_edge");
        irq_chk(0, 1'b0, "warm_irq");
        rd(0, 2'd0, 32'hFFFF_FFFF, "warm_data");

        // Falling edges are ignored by the rising-edge instance.
        set0(32'h0);
        idle(4);
        rd(0, 2'd3, 32'h0, "fall_ignored");
        wr(0, 2'd2, 32'h1);
        rd(0, 2'd2, 32'h1, "mask_rb");

        set0(32'h5);
        idle(3);
        rd(0, 2'd3, 32'h5, "edge_5");
        irq_chk(0, 1'b1, "irq_set");
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h4, "w1c_bit0");
        irq_chk(0, 1'b0, "irq_clr");

        // DATA latency: old value one read after change, new after 2+1.
        set0(32'hA5A5_0000);
        rd(0, 2'd0, 32'h5, "data_old");
        rd(0, 2'd0, 32'hA5A5_0000, "data_new");
        wr(0, 2'd0, 32'hFFFF_FFFF);
        wr(0, 2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd0, 32'hA5A5_0000, "data_ro");
        rd(0, 2'd1, 32'h0, "addr1_zero");
        rd(0, 2'd3, 32'hA5A5_0004, "edge_accum");
        irq_chk(0, 1'b0, "irq_masked");

        // Set beats same-cycle clear.
        wr(0, 2'd3, 32'hFFFF_FFFF);
        wr(0, 2'd2, 32'h8);
        set0(32'hA5A5_0008);
        idle(2);
        wr(0, 2'd3, 32'h8);
        rd(0, 2'd3, 32'h8, "set_priority");
        irq_chk(0, 1'b1, "irq_priority");
        wr(0, 2'd3, 32'h8);
        rd(0, 2'd3, 32'h0, "clr_bit3");

        // Any-edge instance, mask left at 0.
        set2(32'h80);
        idle(3);
        rd(1, 2'd3, 32'h80, "any_rise");
        wr(1, 2'd3, 32'h80);
        set2(32'h0);
        rd(1, 2'd3, 32'h0, "any_cleared");
        irq_chk(1, 1'b0, "any_irq_a");
        rd(1, 2'd3, 32'h80, "any_fall");
        irq_chk(1, 1'b0, "any_irq_b");

        // Async reset mid-operation.
        set0(32'hA5A5_0000);
        idle(4);
        wr(0, 2'd3, 32'hFFFF_FFFF);
        wr(0, 2'd2, 32'hFF);
        set0(32'hA5A5_00FF);
        idle(3);
        rd(0, 2'd3, 32'hFF, "pre_rst_edge");
        irq_chk(0, 1'b1, "pre_rst_irq");
        #2;
        reset_n = 1'b0;
        #1;
        direct("async_readdata", rd0, 32'h0);
        direct("async_irq", {31'b0, irq0}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++)
            rd(0, 2'd3, 32'h0, "warm2_edge");
        rd(0, 2'd2, 32'h0, "mask_reset");
        irq_chk(0, 1'b0, "warm2_irq");
        rd(0, 2'd0, 32'hA5A5_00FF, "data_after_rst");

        idle(3);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
